// File: rtl/ssd_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus. Each digit slot is debounced,
// decoded back to hex, and tracked toward frame completion.
module ssd_scan_decoder #(
  parameter int unsigned NDIG   = 8,
  parameter int unsigned STABLE = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   bad,
  output logic              frame_done,
  output logic [7:0]        frame_count
);

  localparam int unsigned RUN_W    = $clog2(STABLE + 1);
  localparam int unsigned SAMPLE_W = NDIG + 7;
  localparam logic [6:0]  BLANK    = 7'h7F;

  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [NDIG-1:0]     seen_q, seen_d;
  logic [4*NDIG-1:0]   value_q, value_d;
  logic [NDIG-1:0]     valid_q, valid_d;
  logic [NDIG-1:0]     bad_q, bad_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          frame_count_q, frame_count_d;

  logic [SAMPLE_W-1:0] sample_c;
  logic                onehot_c;
  logic                commit_c;
  logic [4:0]          dec_c;
  logic [NDIG-1:0]     seen_nx_c;

  // Returns {hit, nibble} for a legal glyph; hit=0 otherwise.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = {1'b1, 4'h0};
      7'h79: r = {1'b1, 4'h1};
      7'h24: r = {1'b1, 4'h2};
      7'h30: r = {1'b1, 4'h3};
      7'h19: r = {1'b1, 4'h4};
      7'h12: r = {1'b1, 4'h5};
      7'h02: r = {1'b1, 4'h6};
      7'h78: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h18: r = {1'b1, 4'h9};
      7'h08: r = {1'b1, 4'hA};
      7'h03: r = {1'b1, 4'hB};
      7'h46: r = {1'b1, 4'hC};
      7'h21: r = {1'b1, 4'hD};
      7'h06: r = {1'b1, 4'hE};
      7'h0E: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    sample_c      = {dig_sel, seg_n};
    onehot_c      = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
    dec_c         = decode(seg_n);
    prev_d        = sample_c;
    run_d         = '0;
    value_d       = value_q;
    valid_d       = valid_q;
    bad_d         = bad_q;
    seen_d        = seen_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    seen_nx_c     = seen_q | dig_sel;

    // Debounce: count identical one-hot samples, saturating at STABLE.
    if (onehot_c) begin
      if (sample_c == prev_q) begin
        run_d = (run_q == RUN_W'(STABLE)) ? run_q : run_q + RUN_W'(1);
      end else begin
        run_d = RUN_W'(1);
      end
    end
    commit_c = (run_d == RUN_W'(STABLE)) && (run_q != RUN_W'(STABLE));

    if (commit_c) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (dig_sel[i]) begin
          if (dec_c[4]) begin
            value_d[4*i +: 4] = dec_c[3:0];
            valid_d[i]        = 1'b1;
            bad_d[i]          = 1'b0;
          end else if (seg_n == BLANK) begin
            value_d[4*i +: 4] = 4'h0;
            valid_d[i]        = 1'b0;
            bad_d[i]          = 1'b0;
          end else begin
            valid_d[i]        = 1'b0;
            bad_d[i]          = 1'b1;
          end
        end
      end
      // A frame completes on the commit that fills the last unseen slot.
      if (&seen_nx_c) begin
        seen_d        = '0;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 8'(1);
      end else begin
        seen_d        = seen_nx_c;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      prev_q        <= '0;
      run_q         <= '0;
      seen_q        <= '0;
      value_q       <= '0;
      valid_q       <= '0;
      bad_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      prev_q        <= prev_d;
      run_q         <= run_d;
      seen_q        <= seen_d;
      value_q       <= value_d;
      valid_q       <= valid_d;
      bad_q         <= bad_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign value       = value_q;
  assign valid       = valid_q;
  assign bad         = bad_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: glyph sweep, digit scan and debounce/reset corner cases.
module tb_ssd_scan_decoder;

  logic        Clk;
  logic        reset;
  logic [6:0]  seg_n;
  logic [7:0]  dig_sel;
  logic [31:0] value;
  logic [7:0]  valid;
  logic [7:0]  bad;
  logic        frame_done;
  logic [7:0]  frame_count;

  int n_chk  = 0;
  int n_fail = 0;

  ssd_scan_decoder #(.NDIG(8), .STABLE(4)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .value       (value),
    .valid       (valid),
    .bad         (bad),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  dig;
    logic [6:0]  seg;
    int          hold;
    logic [31:0] exp_value;
    logic [7:0]  exp_valid;
    logic [7:0]  exp_bad;
    logic        exp_fd;
    logic [7:0]  exp_fc;
  } vec_t;

  vec_t       scan [8];
  logic [6:0] glyph [16];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] d, input logic [6:0] s, input int n);
    dig_sel = d;
    seg_n   = s;
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] v, input logic [7:0] vl,
                         input logic [7:0] b, input logic fd, input logic [7:0] fc);
    chk({tag, ".value"}, value, v);
    chk({tag, ".valid"}, 32'(valid), 32'(vl));
    chk({tag, ".bad"}, 32'(bad), 32'(b));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(fc));
  endtask

  initial begin
    scan[0] = '{8'h01, 7'h79, 4, 32'h0000_0001, 8'h01, 8'h00, 1'b0, 8'd0};
    scan[1] = '{8'h02, 7'h24, 4, 32'h0000_0021, 8'h03, 8'h00, 1'b0, 8'd0};
    scan[2] = '{8'h04, 7'h30, 4, 32'h0000_0321, 8'h07, 8'h00, 1'b0, 8'd0};
    scan[3] = '{8'h08, 7'h19, 4, 32'h0000_4321, 8'h0F, 8'h00, 1'b0, 8'd0};
    scan[4] = '{8'h10, 7'h12, 4, 32'h0005_4321, 8'h1F, 8'h00, 1'b0, 8'd0};
    scan[5] = '{8'h20, 7'h02, 4, 32'h0065_4321, 8'h3F, 8'h00, 1'b0, 8'd0};
    scan[6] = '{8'h40, 7'h78, 4, 32'h0765_4321, 8'h7F, 8'h00, 1'b0, 8'd0};
    scan[7] = '{8'h80, 7'h00, 4, 32'h8765_4321, 8'hFF, 8'h00, 1'b1, 8'd1};
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    reset   = 1'b1;
    dig_sel = 8'h00;
    seg_n   = 7'h7F;
    tick();
    tick();
    reset = 1'b0;
    chk_all("reset", 32'h0, 8'h00, 8'h00, 1'b0, 8'd0);

    // Single digit: nothing before the 4th edge, committed on it, stable afterwards.
    apply(8'h01, 7'h30, 3);
    chk_all("d0_pre", 32'h0, 8'h00, 8'h00, 1'b0, 8'd0);
    apply(8'h01, 7'h30, 1);
    chk_all("d0_commit", 32'h3, 8'h01, 8'h00, 1'b0, 8'd0);
    apply(8'h01, 7'h30, 10);
    chk_all("d0_held", 32'h3, 8'h01, 8'h00, 1'b0, 8'd0);

    // Short hold on digit 2 is dropped; digit 3 needs 4 edges of its own.
    apply(8'h04, 7'h46, 3);
    apply(8'h08, 7'h46, 3);
    chk_all("d3_pre", 32'h3, 8'h01, 8'h00, 1'b0, 8'd0);
    apply(8'h08, 7'h46, 1);
    chk_all("d3_commit", 32'h0000_C003, 8'h09, 8'h00, 1'b0, 8'd0);

    // Every legal glyph on digit 0, then a bad pattern and a blank.
    for (int i = 0; i < 16; i++) begin
      apply(8'h01, glyph[i], 4);
      chk($sformatf("glyph%0d.nib", i), 32'(value[3:0]), 32'(i));
      chk($sformatf("glyph%0d.valid", i), 32'(valid), 32'h09);
    end
    apply(8'h01, 7'h55, 4);
    chk_all("d0_bad", 32'h0000_C00F, 8'h08, 8'h01, 1'b0, 8'd0);
    apply(8'h01, 7'h7F, 4);
    chk_all("d0_blank", 32'h0000_C000, 8'h08, 8'h00, 1'b0, 8'd0);

    // Full frame scan from a clean state.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply(scan[i].dig, scan[i].seg, scan[i].hold);
      chk_all($sformatf("scan%0d", i), scan[i].exp_value, scan[i].exp_valid,
              scan[i].exp_bad, scan[i].exp_fd, scan[i].exp_fc);
    end
    apply(8'h80, 7'h00, 1);
    chk_all("scan_after", 32'h8765_4321, 8'hFF, 8'h00, 1'b0, 8'd1);

    // Multi-hot select never commits; then an unrecognised pattern on digit 1.
    apply(8'h03, 7'h30, 20);
    chk_all("multihot", 32'h8765_4321, 8'hFF, 8'h00, 1'b0, 8'd1);
    apply(8'h02, 7'h55, 4);
    chk_all("d1_bad", 32'h8765_4321, 8'hFD, 8'h02, 1'b0, 8'd1);

    // Digit 5 as E, then blanked.
    apply(8'h20, 7'h06, 4);
    chk_all("d5_E", 32'h87E5_4321, 8'hFD, 8'h02, 1'b0, 8'd1);
    apply(8'h20, 7'h7F, 4);
    chk_all("d5_blank", 32'h8705_4321, 8'hDD, 8'h02, 1'b0, 8'd1);

    // Reset on the would-be commit edge wins; the held input restarts its run.
    apply(8'h01, 7'h30, 3);
    chk_all("rst_pre", 32'h8705_4321, 8'hDD, 8'h02, 1'b0, 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("rst_commit_edge", 32'h0, 8'h00, 8'h00, 1'b0, 8'd0);
    apply(8'h01, 7'h30, 3);
    chk_all("rst_rerun_pre", 32'h0, 8'h00, 8'h00, 1'b0, 8'd0);
    apply(8'h01, 7'h30, 1);
    chk_all("rst_rerun", 32'h3, 8'h01, 8'h00, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
